my_serial_to_parallel: RTL
==========================

Name: my_serial_to_parallel

Overview:
- Receive-side SIPO stage directly downstream of the team's parallel-to-serial shifter.
- Consumes its LSB-first SERIAL_OUT stream, qualified by a per-bit enable and a start-of-frame marker.
- Reassembles N-bit words and presents them on a registered parallel output with a VALID/ACK handshake.
- Flags overrun when a word is lost because the consumer has not acknowledged it.

Parameters:
- N, 4, word width in bits; legal range N >= 2.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RESET  input  1  synchronous, active-high reset; one clock, sampled on the rising edge of CLK.
- EN  input  1  bit strobe; SERIAL_IN is sampled only on edges where EN=1.
- SOF  input  1  start of frame; qualifies the current EN bit as bit 0 of a new word; ignored when EN=0.
- SERIAL_IN  input  1  serial data, LSB first.
- ACK  input  1  consumer acknowledge of DATAR.
- DATAR  output  N  last completed word, registered.
- VALID  output  1  DATAR holds an unacknowledged word.
- OVERRUN  output  1  sticky; an unacknowledged word was overwritten.
- BUSY  output  1  frame in progress (state = RECEIVE), decoded from the state register.

Behaviour:
- Reset:
  - RESET=1 at an edge forces state IDLE, shift register 0, bit count 0, DATAR 0, VALID 0, OVERRUN 0.
  - This applies mid-frame: the partial word is discarded with no VALID.
  - RESET has priority over every other input.
- Bit order:
  - Each accepted bit is shifted in as shift <= {SERIAL_IN, shift[N-1:1]}.
  - The first bit received ends up in DATAR[0], matching the upstream right-shifting PISO.
- States: IDLE, RECEIVE.
  - IDLE, EN=1 and SOF=1: shift bit, count <= 1, go to RECEIVE.
  - IDLE, EN=1 and SOF=0: bit ignored, no state change.
  - IDLE, EN=0: hold.
  - RECEIVE, EN=0: hold everything (gaps between bits are legal and unbounded).
  - RECEIVE, EN=1 and SOF=1: abort the partial frame; restart as bit 0 (shift bit, count <= 1, stay in RECEIVE); no VALID for the aborted frame.
  - RECEIVE, EN=1, SOF=0, count < N-1: shift bit, count <= count + 1.
  - RECEIVE, EN=1, SOF=0, count = N-1 (Nth bit): DATAR <= {SERIAL_IN, shift[N-1:1]}, word-complete event, count <= 0, go to IDLE.
- Counter:
  - Width $clog2(N).
  - Never exceeds N-1 and never wraps while in RECEIVE.
- Latency:
  - VALID and the new DATAR are visible the cycle after the edge that sampled the Nth bit.
  - Back-to-back frames are legal: SOF may coincide with the first EN after completion, with no dead cycle.
- Handshake:
  - VALID is set on word-complete and cleared on the edge where ACK=1 and no new word completes.
  - ACK while VALID=0 has no effect.
  - DATAR is stable whenever no word completes.
- Overrun:
  - Word completes while VALID=1 and ACK=0: DATAR is overwritten with the new word, VALID stays 1, OVERRUN <= 1.
  - OVERRUN is cleared by ACK.
  - Word completes on the same edge as ACK=1: the new word is loaded, VALID stays 1, OVERRUN <= 0.

Decomposition:
- Package my_serial_pkg:
  - typedef enum logic {IDLE, RECEIVE} rx_state_t.
  - function/localparam for counter width CNT_W = $clog2(N) (overridable per instance).
- One sub-module: my_sipo_holding_reg (N-bit DATAR, VALID, OVERRUN, ACK handshake).
  - Inputs: load strobe and word.
  - Top keeps the FSM, counter and shift register.

Test Plan (N=4):
- Reset: drive RESET=1 for 2 cycles with EN=1 and random data -> DATAR=0, VALID=0, OVERRUN=0, BUSY=0.
- Basic frame: EN=1 on 4 consecutive cycles, SOF on the first, bits 1,1,0,1 -> one cycle later VALID=1, DATAR=4'hB, BUSY=0; ACK=1 for one cycle -> VALID=0 next cycle, DATAR stays 4'hB.
- EN gaps and loopback: drive the upstream PISO loaded with 4'h9 into this block, inserting EN=0 gaps of 3 cycles between bits -> BUSY=1 throughout the frame, DATAR=4'h9, exactly one VALID rise.
- SOF restart: send 2 bits of any word, then SOF with bits 0,1,1,0 -> DATAR=4'h6, single VALID, no OVERRUN.
- Overrun: frames 4'h3 then 4'hC back-to-back with no ACK -> DATAR=4'hC, VALID=1, OVERRUN=1; ACK -> both 0.
  - Repeat with ACK on the completion edge of the second frame -> VALID=1, OVERRUN=0, DATAR=4'hC.
- Reset mid-frame: 2 bits in, RESET=1 for 1 cycle, then 2 bits without SOF -> no VALID, BUSY=0, DATAR=0.

Source files
------------

// File: rtl/my_serial_pkg.sv
// Shared types and sizing helpers for the serial-to-parallel receive stage.
package my_serial_pkg;

   typedef enum logic {IDLE, RECEIVE} rx_state_t;

   // Bit-count width; a 2-bit word still needs one counter bit.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/my_serial_to_parallel_if.sv
// Serial receive stream plus parallel VALID/ACK result bus of the SIPO stage.
interface my_serial_to_parallel_if #(
   parameter int N = 4
);
   logic         EN;
   logic         SOF;
   logic         SERIAL_IN;
   logic         ACK;
   logic [N-1:0] DATAR;
   logic         VALID;
   logic         OVERRUN;
   logic         BUSY;

   modport master (
      output EN, SOF, SERIAL_IN, ACK,
      input  DATAR, VALID, OVERRUN, BUSY
   );

   modport slave (
      input  EN, SOF, SERIAL_IN, ACK,
      output DATAR, VALID, OVERRUN, BUSY
   );
endinterface

// File: rtl/my_sipo_holding_reg.sv
// Output holding register: captures completed words and runs the VALID/ACK
// handshake with a sticky overrun flag.
module my_sipo_holding_reg #(
   parameter int N = 4
) (
   input  logic         CLK,
   input  logic         RESET,
   input  logic         load,
   input  logic [N-1:0] word,
   input  logic         ack,
   output logic [N-1:0] datar,
   output logic         valid,
   output logic         overrun
);

   logic [N-1:0] data_reg;
   logic         valid_reg;
   logic         overrun_reg;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         data_reg    <= '0;
         valid_reg   <= 1'b0;
         overrun_reg <= 1'b0;
      end else if (load) begin
         data_reg  <= word;
         valid_reg <= 1'b1;
         // An ACK on the completion edge consumes the old word, so nothing is lost.
         if (ack)
            overrun_reg <= 1'b0;
         else if (valid_reg)
            overrun_reg <= 1'b1;
      end else if (ack) begin
         valid_reg   <= 1'b0;
         overrun_reg <= 1'b0;
      end
   end

   assign datar   = data_reg;
   assign valid   = valid_reg;
   assign overrun = overrun_reg;

endmodule

// File: rtl/my_serial_to_parallel.sv
// LSB-first serial-to-parallel receiver: frame FSM, bit counter and shift
// register feeding a VALID/ACK holding register.
module my_serial_to_parallel
   import my_serial_pkg::*;
#(
   parameter int N     = 4,
   parameter int CNT_W = cnt_width(N)
) (
   input  logic                   CLK,
   input  logic                   RESET,
   my_serial_to_parallel_if.slave bus
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

   rx_state_t        state_reg;
   logic [CNT_W-1:0] count_reg;
   // Only the upper N-1 bits of the shift window are stored; the Nth bit
   // arrives straight from SERIAL_IN on the completing edge.
   logic [N-2:0]     shift_reg;
   logic [N-1:0]     word_next;
   logic             load_next;

   assign word_next = {bus.SERIAL_IN, shift_reg};
   assign load_next = (state_reg == RECEIVE) && bus.EN && !bus.SOF
                      && (count_reg == LAST_CNT);

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_reg <= IDLE;
         count_reg <= '0;
         shift_reg <= '0;
      end else if (bus.EN) begin
         if (bus.SOF) begin
            // SOF always starts a fresh word, aborting any partial frame.
            shift_reg <= word_next[N-1:1];
            count_reg <= CNT_W'(1);
            state_reg <= RECEIVE;
         end else if (state_reg == RECEIVE) begin
            shift_reg <= word_next[N-1:1];
            if (count_reg == LAST_CNT) begin
               count_reg <= '0;
               state_reg <= IDLE;
            end else begin
               count_reg <= count_reg + CNT_W'(1);
            end
         end
      end
   end

   assign bus.BUSY = (state_reg == RECEIVE);

   my_sipo_holding_reg #(
      .N (N)
   ) u_holding (
      .CLK     (CLK),
      .RESET   (RESET),
      .load    (load_next),
      .word    (word_next),
      .ack     (bus.ACK),
      .datar   (bus.DATAR),
      .valid   (bus.VALID),
      .overrun (bus.OVERRUN)
   );

endmodule
